sram_a_skew_reader: RTL and testbench



---
 rtl/sram_a_skew_if.sv | 29 ++
 rtl/sram_a_skew_reader.sv | 94 +++++++++
 tb/tb_sram_a_skew_reader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/sram_a_skew_if.sv
// Bundle between the tile controller / A SRAM and the skewed A-operand reader.
// master: controller + SRAM side, slave: the reader.
interface sram_a_skew_if #(
   parameter int ENTRYS  = 16,
   parameter int RDWIDTH = 4
);
   localparam int AW = $clog2(ENTRYS);

   logic                          start;
   logic [AW:0]                   k_len;
   logic                          stall;
   logic                          busy;
   logic                          done;
   logic [7:0][AW-1:0]            rdaddr;
   logic [7:0]                    re;
   logic [7:0][8*RDWIDTH-1:0]     sram_data;
   logic [7:0][8*RDWIDTH-1:0]     pe_data;
   logic [7:0]                    pe_valid;

   modport master (
      output start, k_len, stall, sram_data,
      input  busy, done, rdaddr, re, pe_data, pe_valid
   );

   modport slave (
      input  start, k_len, stall, sram_data,
      output busy, done, rdaddr, re, pe_data, pe_valid
   );
endinterface

// File: rtl/sram_a_skew_reader.sv
// Skewed read sequencer for the A-operand SRAM: row i lags row i-1 by one cycle.
// Optional SRAM_RD_ZERO_FILL_EN masks pe_data to zero whenever pe_valid is low.
//
// state | meaning
// IDLE  | waiting for start with nonzero k_len
// RUN   | stepping t, issuing skewed per-row reads
// DONE  | one-cycle done pulse with the last row-7 beat
module sram_a_skew_reader #(
   parameter int ENTRYS  = 16,
   parameter int RDWIDTH = 4
) (
   input logic          clk,
   input logic          rst,
   sram_a_skew_if.slave bus
);
   localparam int AW = $clog2(ENTRYS);
   localparam int TW = AW + 4;
   localparam int DW = 8 * RDWIDTH;
   localparam logic [AW:0] LEN_MAX = (AW+1)'(ENTRYS);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e              state_q, state_d;
   logic [TW-1:0]       t_q, t_d;
   logic [AW:0]         len_q, len_d;
   logic [7:0]          pe_valid_q;
   logic [7:0]          re_c;
   logic [7:0][AW-1:0]  rdaddr_c;
   logic [7:0][DW-1:0]  pe_data_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         t_q        <= '0;
         len_q      <= '0;
         pe_valid_q <= '0;
      end else begin
         state_q    <= state_d;
         t_q        <= t_d;
         len_q      <= len_d;
         pe_valid_q <= re_c;
      end
   end

   always_comb begin
      state_d  = state_q;
      t_d      = t_q;
      len_d    = len_q;
      re_c     = '0;
      rdaddr_c = '0;
      unique case (state_q)
         IDLE: begin
            if (bus.start && (bus.k_len != '0)) begin
               state_d = RUN;
               t_d     = '0;
               len_d   = (bus.k_len > LEN_MAX) ? LEN_MAX : bus.k_len;
            end
         end
         RUN: begin
            // row i is active for t in [i, i+len)
            for (int i = 0; i < 8; i++) begin
               if (!bus.stall && (t_q >= TW'(i)) && ((t_q - TW'(i)) < TW'(len_q))) begin
                  re_c[i]     = 1'b1;
                  rdaddr_c[i] = AW'(t_q - TW'(i));
               end
            end
            if (!bus.stall) begin
               t_d = t_q + 1'b1;
               if (t_q == (TW'(len_q) + TW'(6))) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pe_data_c = '0;
      for (int i = 0; i < 8; i++) begin
`ifdef SRAM_RD_ZERO_FILL_EN
         pe_data_c[i] = pe_valid_q[i] ? bus.sram_data[i] : {DW{1'b0}};
`else
         pe_data_c[i] = bus.sram_data[i];
`endif
      end
   end

   assign bus.re       = re_c;
   assign bus.rdaddr   = rdaddr_c;
   assign bus.pe_valid = pe_valid_q;
   assign bus.pe_data  = pe_data_c;
   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = (state_q == DONE);
endmodule

// File: tb/tb_sram_a_skew_reader.sv
// Directed bench for sram_a_skew_reader: table of tiles plus hand sequences
// for start-ignore, mid-tile reset and pe_data masking.
module tb_sram_a_skew_reader;
   logic clk = 1'b0;
   logic rst;
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   sram_a_skew_if #(.ENTRYS(16), .RDWIDTH(4)) bif ();

   sram_a_skew_reader #(.ENTRYS(16), .RDWIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] k_len;
      int         st_r;      // first stalled cycle (relative to start edge), 0 = none
      int         st_n;      // stalled cycle count
      int         exp_len;   // beats per row
      int         exp_done;  // cycle of done pulse, 0 = none
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string nm, input longint act, input longint exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic drive_data(input int r);
      for (int i = 0; i < 8; i++) bif.sram_data[i] = {8{4'(r + i)}};
   endtask

   task automatic run_vec(input vec_t v);
      int next_a[8];
      int beats[8];
      int first_pv[8];
      int dones;
      int done_r;
      int stalls;
      for (int i = 0; i < 8; i++) begin
         next_a[i] = 0; beats[i] = 0; first_pv[i] = 0;
      end
      dones = 0; done_r = 0; stalls = 0;
      @(negedge clk);
      bif.start = 1'b1;
      bif.k_len = v.k_len;
      for (int r = 1; r <= 32; r++) begin
         @(posedge clk);
         #1;
         bif.start = 1'b0;
         bif.stall = (v.st_n != 0) && (r >= v.st_r) && (r < v.st_r + v.st_n);
         drive_data(r);
         #1;
         if (r == 1) check("busy_after_start", bif.busy, v.exp_len != 0);
         for (int i = 0; i < 8; i++) begin
            if (bif.re[i]) begin
               check("rdaddr_seq", bif.rdaddr[i], next_a[i]);
               check("rdaddr_cycle", r, 1 + i + next_a[i] + stalls);
               next_a[i]++;
            end
            if (bif.pe_valid[i]) begin
               beats[i]++;
               if (first_pv[i] == 0) first_pv[i] = r;
               check("pe_data_beat", bif.pe_data[i], bif.sram_data[i]);
            end
         end
         if (bif.stall) check("re_low_in_stall", bif.re, 0);
         if ((v.st_n != 0) && (r > v.st_r) && (r <= v.st_r + v.st_n))
            check("pe_valid_low_after_stall", bif.pe_valid, 0);
         if (bif.done) begin
            dones++;
            done_r = r;
         end
         if ((v.exp_done != 0) && (r == v.exp_done + 1)) check("busy_falls", bif.busy, 0);
         if (bif.stall) stalls++;
      end
      bif.stall = 1'b0;
      check("done_count", dones, (v.exp_done != 0) ? 1 : 0);
      check("done_cycle", done_r, v.exp_done);
      for (int i = 0; i < 8; i++) begin
         check("row_beats", beats[i], v.exp_len);
         check("row_reads", next_a[i], v.exp_len);
         if ((v.st_n == 0) && (v.exp_len != 0)) check("row_first_valid", first_pv[i], 2 + i);
      end
   endtask

   initial begin
      int dones;
      vecs[0] = '{k_len: 5'd16, st_r: 0, st_n: 0, exp_len: 16, exp_done: 24};
      vecs[1] = '{k_len: 5'd3,  st_r: 0, st_n: 0, exp_len: 3,  exp_done: 11};
      vecs[2] = '{k_len: 5'd20, st_r: 0, st_n: 0, exp_len: 16, exp_done: 24};
      vecs[3] = '{k_len: 5'd0,  st_r: 0, st_n: 0, exp_len: 0,  exp_done: 0};
      vecs[4] = '{k_len: 5'd4,  st_r: 6, st_n: 2, exp_len: 4,  exp_done: 14};
      vecs[5] = '{k_len: 5'd1,  st_r: 0, st_n: 0, exp_len: 1,  exp_done: 9};

      rst = 1'b1;
      bif.start = 1'b0;
      bif.k_len = '0;
      bif.stall = 1'b0;
      bif.sram_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", bif.busy, 0);
      check("rst_done", bif.done, 0);
      check("rst_re", bif.re, 0);
      check("rst_rdaddr", bif.rdaddr, 0);
      check("rst_pe_valid", bif.pe_valid, 0);
      rst = 1'b0;

      // idle row with all-ones data: masked only in zero-fill builds
      for (int i = 0; i < 8; i++) bif.sram_data[i] = 32'hFFFF_FFFF;
      #1;
`ifdef SRAM_RD_ZERO_FILL_EN
      check("zero_fill_row3", bif.pe_data[3], 32'h0);
`else
      check("passthru_row3", bif.pe_data[3], 32'hFFFF_FFFF);
`endif

      for (int v = 0; v < 6; v++) run_vec(vecs[v]);

      // start held through RUN and DONE is ignored; accepted in following IDLE cycle
      dones = 0;
      @(negedge clk);
      bif.start = 1'b1;
      bif.k_len = 5'd2;
      for (int r = 1; r <= 26; r++) begin
         @(posedge clk);
         #1;
         bif.start = (r >= 4) && (r <= 11);
         bif.k_len = 5'd1;
         drive_data(r);
         #1;
         if (bif.done) begin
            dones++;
            if (dones == 1) check("first_done_cycle", r, 10);
            else check("second_done_cycle", r, 20);
         end
      end
      bif.start = 1'b0;
      check("start_ignore_dones", dones, 2);

      // reset at t=6 of a 16-entry tile
      dones = 0;
      @(negedge clk);
      bif.start = 1'b1;
      bif.k_len = 5'd16;
      for (int r = 1; r <= 30; r++) begin
         @(posedge clk);
         #1;
         bif.start = 1'b0;
         rst = (r == 7);
         drive_data(r);
         #1;
         if (r == 8) begin
            check("midrst_busy", bif.busy, 0);
            check("midrst_done", bif.done, 0);
            check("midrst_re", bif.re, 0);
            check("midrst_rdaddr", bif.rdaddr, 0);
            check("midrst_pe_valid", bif.pe_valid, 0);
         end
         if ((r >= 7) && bif.done) dones++;
      end
      rst = 1'b0;
      check("midrst_no_done", dones, 0);
      run_vec('{k_len: 5'd2, st_r: 0, st_n: 0, exp_len: 2, exp_done: 10});

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
